// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared definitions for the registered bitwise logic unit.
//   - opcode constants OP_AND .. OP_NOT_A (3-bit)
//   - skid-buffer state encoding ST_EMPTY / ST_ONE / ST_TWO (2-bit)
//   - logic_eval(): the combinational function of every opcode, evaluated
//     at the maximum operand width (64); callers truncate to their width
//   - parity64(): XOR-reduction helper for the optional result flags
package logic_unit_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_NAND   = 3'd3;
  localparam logic [2:0] OP_NOR    = 3'd4;
  localparam logic [2:0] OP_XNOR   = 3'd5;
  localparam logic [2:0] OP_PASS_A = 3'd6;
  localparam logic [2:0] OP_NOT_A  = 3'd7;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Operands narrower than 64 bits are zero-extended by the caller; the
  // inverted upper bits that NAND/NOR/XNOR/NOT produce are discarded when
  // the caller truncates back to its own width.
  function automatic logic [MAX_W-1:0] logic_eval(input logic [2:0]       op,
                                                  input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] y;
    case (op)
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_NAND:   y = ~(a & b);
      OP_NOR:    y = ~(a | b);
      OP_XNOR:   y = ~(a ^ b);
      OP_PASS_A: y = a;
      OP_NOT_A:  y = ~a;
      default:   y = {MAX_W{1'b0}};
    endcase
    return y;
  endfunction

  // Zero-extension does not change the XOR-reduction, so narrower values
  // can be passed in directly.
  function automatic logic parity64(input logic [MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/logic_unit_skid_buffer.sv
// skid_buffer: 2-entry valid/ready pipeline stage (output register OUT plus
// skid register SKID) carrying an opaque payload of PW bits.
//   clock, reset         rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  upstream handshake; in_ready depends on state only
//   in_data  [PW-1:0]    payload captured on an input transfer
//   out_valid/out_ready  downstream handshake
//   out_data [PW-1:0]    payload held stable while out_valid && !out_ready
// RESET_VAL is the value OUT and SKID take on reset.
module skid_buffer
  import logic_unit_pkg::*;
#(
  parameter int            PW        = 11,
  parameter logic [PW-1:0] RESET_VAL = {PW{1'b0}}
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  state_e        state_r;
  state_e        state_s;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [PW-1:0] out_data_r;
  logic [PW-1:0] skid_data_r;
  logic          accept_s;
  logic          drain_s;
  logic          load_out_in_s;
  logic          load_out_skid_s;
  logic          load_skid_s;

  // in_ready is forced low while reset is held so nothing is accepted in
  // the reset cycle; out_ready never reaches it.
  assign in_ready  = in_ready_r & ~reset;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  assign accept_s = in_valid & in_ready;
  assign drain_s  = out_valid_r & out_ready;

  // Next-state and register-load selection.
  always_comb begin
    state_s         = state_r;
    load_out_in_s   = 1'b0;
    load_out_skid_s = 1'b0;
    load_skid_s     = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_s       = ST_ONE;
          load_out_in_s = 1'b1;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && drain_s) begin
          state_s       = ST_ONE;
          load_out_in_s = 1'b1;
        end else if (accept_s) begin
          state_s     = ST_TWO;
          load_skid_s = 1'b1;
        end else if (drain_s) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (drain_s) begin
          state_s         = ST_ONE;
          load_out_skid_s = 1'b1;
        end else begin
          state_s = ST_TWO;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // State, registered handshake outputs and payload storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= RESET_VAL;
      skid_data_r <= RESET_VAL;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s != ST_TWO);
      out_valid_r <= (state_s != ST_EMPTY);
      if (load_out_in_s) begin
        out_data_r <= in_data;
      end else if (load_out_skid_s) begin
        out_data_r <= skid_data_r;
      end
      if (load_skid_s) begin
        skid_data_r <= in_data;
      end
    end
  end

endmodule

// File: rtl/logic_unit.sv
// logic_unit: registered two-operand bitwise logic unit with valid/ready
// handshake on both sides and a 2-entry skid buffer.
//   clock, reset           rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    upstream handshake
//   in_a, in_b [WIDTH-1:0] operands (in_b ignored for PASS_A / NOT_A)
//   in_op [2:0]            opcode, see logic_unit_pkg
//   out_valid / out_ready  downstream handshake
//   out_y [WIDTH-1:0]      result, out_op [2:0] opcode that produced it
//   count [COUNT_W-1:0]    saturating number of delivered results
// Optional macro LOGIC_UNIT_FLAGS_EN adds out_zero (out_y == 0) and
// out_parity (^out_y), carried through the buffer with the result.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic [2:0]         out_op,
  output logic [COUNT_W-1:0] count
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic               out_zero,
  output logic               out_parity
`endif
);

`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int FLAG_W = 2;
`else
  localparam int FLAG_W = 0;
`endif
  localparam int PW = WIDTH + 3 + FLAG_W;

  // Payload layout, MSB first: [zero, parity,] op, y.
`ifdef LOGIC_UNIT_FLAGS_EN
  localparam logic [PW-1:0] RESET_VAL = {1'b1, 1'b0, 3'b000, {WIDTH{1'b0}}};
`else
  localparam logic [PW-1:0] RESET_VAL = {3'b000, {WIDTH{1'b0}}};
`endif

  logic [WIDTH-1:0]   y_s;
  logic [PW-1:0]      in_data_s;
  logic [PW-1:0]      out_data_s;
  logic               drain_s;
  logic [COUNT_W-1:0] count_r;

  assign y_s = WIDTH'(logic_eval(in_op, MAX_W'(in_a), MAX_W'(in_b)));

`ifdef LOGIC_UNIT_FLAGS_EN
  assign in_data_s = {(y_s == {WIDTH{1'b0}}), parity64(MAX_W'(y_s)), in_op, y_s};
  assign out_zero   = out_data_s[WIDTH+4];
  assign out_parity = out_data_s[WIDTH+3];
`else
  assign in_data_s = {in_op, y_s};
`endif

  assign out_y  = out_data_s[WIDTH-1:0];
  assign out_op = out_data_s[WIDTH+2:WIDTH];

  skid_buffer #(
    .PW        (PW),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data_s)
  );

  assign drain_s = out_valid & out_ready;
  assign count   = count_r;

  // Delivered-result counter, holding at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {COUNT_W{1'b0}};
    end else if (drain_s && (count_r != {COUNT_W{1'b1}})) begin
      count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_logic_unit.sv
module tb_logic_unit;
  import logic_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=1 instance
  logic       v1 = 1'b0, ord1 = 1'b1, ir1, ov1;
  logic [0:0] a1 = 1'b0, b1 = 1'b0, y1;
  logic [2:0] op1 = 3'd0, oop1;
  logic [15:0] cnt1;
  // WIDTH=8 instance
  logic       v8 = 1'b0, ord8 = 1'b1, ir8, ov8;
  logic [7:0] a8 = 8'h00, b8 = 8'h00, y8;
  logic [2:0] op8 = 3'd0, oop8;
  logic [15:0] cnt8;
  // WIDTH=8, COUNT_W=4 instance
  logic       vs = 1'b0, ords = 1'b1, irs, ovs;
  logic [7:0] as_ = 8'h00, bs = 8'h00, ys;
  logic [2:0] ops = 3'd0, oops;
  logic [3:0] cnts;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic z1, p1, z8, p8, zs, ps;
`endif

  logic_unit #(.WIDTH(1), .COUNT_W(16)) dut1 (
    .clock(clk), .reset(rst), .in_valid(v1), .in_ready(ir1), .in_a(a1), .in_b(b1),
    .in_op(op1), .out_valid(ov1), .out_ready(ord1), .out_y(y1), .out_op(oop1), .count(cnt1)
`ifdef LOGIC_UNIT_FLAGS_EN
    , .out_zero(z1), .out_parity(p1)
`endif
  );
  logic_unit #(.WIDTH(8), .COUNT_W(16)) dut8 (
    .clock(clk), .reset(rst), .in_valid(v8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_op(op8), .out_valid(ov8), .out_ready(ord8), .out_y(y8), .out_op(oop8), .count(cnt8)
`ifdef LOGIC_UNIT_FLAGS_EN
    , .out_zero(z8), .out_parity(p8)
`endif
  );
  logic_unit #(.WIDTH(8), .COUNT_W(4)) duts (
    .clock(clk), .reset(rst), .in_valid(vs), .in_ready(irs), .in_a(as_), .in_b(bs),
    .in_op(ops), .out_valid(ovs), .out_ready(ords), .out_y(ys), .out_op(oops), .count(cnts)
`ifdef LOGIC_UNIT_FLAGS_EN
    , .out_zero(zs), .out_parity(ps)
`endif
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  vec_t       vtab1[32];
  vec_t       vtab8[8];
  logic [3:0] tt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Truth tables indexed by {a,b}: bit3 = (1,1) ... bit0 = (0,0)
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b1100; tt[7] = 4'b0011;
    for (int i = 0; i < 32; i++) begin
      vtab1[i].op = 3'(i / 4);
      vtab1[i].a  = 8'((i % 4) / 2);
      vtab1[i].b  = 8'(i % 2);
      vtab1[i].y  = {7'd0, tt[i / 4][i % 4]};
    end
    vtab8[0] = '{OP_XOR,    8'hF0, 8'h3C, 8'hCC};
    vtab8[1] = '{OP_NAND,   8'hF0, 8'h3C, 8'hCF};
    vtab8[2] = '{OP_AND,    8'hFF, 8'h0F, 8'h0F};
    vtab8[3] = '{OP_OR,     8'h01, 8'h80, 8'h81};
    vtab8[4] = '{OP_NOR,    8'hF0, 8'h0F, 8'h00};
    vtab8[5] = '{OP_XNOR,   8'hAA, 8'h55, 8'h00};
    vtab8[6] = '{OP_PASS_A, 8'h5A, 8'hFF, 8'h5A};
    vtab8[7] = '{OP_NOT_A,  8'h5A, 8'h00, 8'hA5};

    // Reset state
    step(); step();
    chk("in_ready_during_reset", ir8, 1'b0);
    rst = 1'b0;
    step();
    chk("rst_in_ready", ir8, 1'b1);
    chk("rst_out_valid", ov8, 1'b0);
    chk("rst_out_y", y8, 8'h00);
    chk("rst_out_op", oop8, 3'd0);
    chk("rst_count", cnt8, 16'd0);
`ifdef LOGIC_UNIT_FLAGS_EN
    chk("rst_zero", z8, 1'b1);
    chk("rst_parity", p8, 1'b0);
`endif

    // Exhaustive WIDTH=1, back-to-back with out_ready=1
    for (int i = 0; i < 32; i++) begin
      v1 = 1'b1; op1 = vtab1[i].op; a1 = vtab1[i].a[0]; b1 = vtab1[i].b[0];
      step();
      chk($sformatf("w1_valid_%0d", i), ov1, 1'b1);
      chk($sformatf("w1_y_%0d", i), y1, vtab1[i].y[0]);
      chk($sformatf("w1_op_%0d", i), oop1, vtab1[i].op);
    end
    v1 = 1'b0;
    step();
    chk("w1_count", cnt1, 16'd32);
    chk("w1_drained", ov1, 1'b0);

    // WIDTH=8 directed vectors
    for (int i = 0; i < 8; i++) begin
      v8 = 1'b1; op8 = vtab8[i].op; a8 = vtab8[i].a; b8 = vtab8[i].b;
      step();
      chk($sformatf("w8_valid_%0d", i), ov8, 1'b1);
      chk($sformatf("w8_y_%0d", i), y8, vtab8[i].y);
      chk($sformatf("w8_op_%0d", i), oop8, vtab8[i].op);
    end
    v8 = 1'b0;
    step();
    chk("w8_count", cnt8, 16'd8);

    // Backpressure fills OUT then SKID
    ord8 = 1'b0;
    v8 = 1'b1; op8 = OP_AND; a8 = 8'hFF; b8 = 8'h0F;
    step();
    chk("bp_one_ready", ir8, 1'b1);
    chk("bp_one_y", y8, 8'h0F);
    v8 = 1'b1; op8 = OP_OR; a8 = 8'h01; b8 = 8'h80;
    step();
    v8 = 1'b0;
    chk("bp_two_ready", ir8, 1'b0);
    chk("bp_two_y", y8, 8'h0F);
    step();
    chk("bp_hold_y", y8, 8'h0F);
    chk("bp_hold_op", oop8, OP_AND);
    chk("bp_hold_ready", ir8, 1'b0);
    ord8 = 1'b1;
    #1;
    chk("bp_first_out", y8, 8'h0F);
    step();
    chk("bp_second_valid", ov8, 1'b1);
    chk("bp_second_out", y8, 8'h81);
    chk("bp_second_op", oop8, OP_OR);
    chk("bp_ready_back", ir8, 1'b1);
    step();
    chk("bp_empty", ov8, 1'b0);
    chk("bp_count", cnt8, 16'd10);

    // 20 back-to-back transfers, plus saturation on the 4-bit counter
    rst = 1'b1; step(); rst = 1'b0; step();
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("b2b_ready_%0d", i), ir8, 1'b1);
      v8 = 1'b1; op8 = OP_XOR; a8 = 8'(i); b8 = 8'h0F;
      vs = 1'b1; ops = OP_PASS_A; as_ = 8'(i); bs = 8'h00;
      step();
      chk($sformatf("b2b_valid_%0d", i), ov8, 1'b1);
      chk($sformatf("b2b_y_%0d", i), y8, 8'(i) ^ 8'h0F);
    end
    v8 = 1'b0; vs = 1'b0;
    step();
    chk("b2b_count", cnt8, 16'd20);
    chk("sat_count", cnts, 4'd15);
    for (int i = 0; i < 3; i++) begin
      vs = 1'b1; as_ = 8'(i);
      step();
    end
    vs = 1'b0;
    step();
    chk("sat_hold", cnts, 4'd15);

    // Reset while in TWO
    ord8 = 1'b0;
    v8 = 1'b1; op8 = OP_PASS_A; a8 = 8'h11; b8 = 8'h00;
    step();
    a8 = 8'h22;
    step();
    v8 = 1'b0;
    chk("two_before_reset", ir8, 1'b0);
    rst = 1'b1;
    #1;
    chk("two_reset_ready", ir8, 1'b0);
    step();
    chk("rst2_valid", ov8, 1'b0);
    chk("rst2_count", cnt8, 16'd0);
    chk("rst2_y", y8, 8'h00);
    chk("rst2_op", oop8, 3'd0);
    rst = 1'b0; ord8 = 1'b1;
    v8 = 1'b1; op8 = OP_PASS_A; a8 = 8'h07; b8 = 8'hFF;
    step();
    chk("post_rst_valid", ov8, 1'b1);
    chk("post_rst_y", y8, 8'h07);
`ifdef LOGIC_UNIT_FLAGS_EN
    chk("flag_zero_07", z8, 1'b0);
    chk("flag_par_07", p8, 1'b1);
`endif
    a8 = 8'h00;
    step();
    chk("post_rst_y0", y8, 8'h00);
`ifdef LOGIC_UNIT_FLAGS_EN
    chk("flag_zero_00", z8, 1'b1);
    chk("flag_par_00", p8, 1'b0);
`endif
    v8 = 1'b0;
    step();
    chk("post_rst_count", cnt8, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
